// File: rtl/echo_capture.sv
// echo_capture
// Capture stage feeding the UART uploader. A START request runs GROUP_NUM
// probe groups. Each group waits for TRIG, stores PULSE_LEN complex ADC
// samples ({IM, RE}) into an internal buffer, pulses RE_OVER, then holds
// the buffer stable until the uploader reports OVER=1. After the last group
// EXECUT_OVER is pulsed for one cycle.
//
// Ports:
//   CLOCK_10M    in   sole clock
//   RESET_N      in   asynchronous active-low reset
//   START        in   one-cycle run request (honoured only when idle)
//   OVER         in   uploader level: 0 while uploading, 1 when done
//   CFG_LEN[16]  in   requested samples per group (clamped to MAX_LEN)
//   TRIG         in   pulse-start strobe (arms a capture)
//   ADC_VALID    in   sample strobe
//   ADC_RE[16]   in   real sample
//   ADC_IM[16]   in   imaginary sample
//   ADDR[16]     in   uploader read address
//   DATA[32]     out  {IM, RE} at ADDR, combinational read
//   PULSE_LEN[16] out clamped length latched at START
//   RE_OVER      out  one-cycle pulse: group buffer ready
//   EXECUT_OVER  out  one-cycle pulse: run complete
//   BUSY         out  high whenever not idle
//   GROUP_CNT[16] out groups completed in the current run
module echo_capture #(
  parameter int GROUP_NUM = 8,
  parameter int MAX_LEN   = 320,
  parameter int AW        = 9
) (
  input  logic        CLOCK_10M,
  input  logic        RESET_N,
  input  logic        START,
  input  logic        OVER,
  input  logic [15:0] CFG_LEN,
  input  logic        TRIG,
  input  logic        ADC_VALID,
  input  logic [15:0] ADC_RE,
  input  logic [15:0] ADC_IM,
  input  logic [15:0] ADDR,
  output logic [31:0] DATA,
  output logic [15:0] PULSE_LEN,
  output logic        RE_OVER,
  output logic        EXECUT_OVER,
  output logic        BUSY,
  output logic [15:0] GROUP_CNT
);

  localparam logic [15:0] MAX_LEN16   = 16'(MAX_LEN);
  localparam logic [15:0] GROUP_NUM16 = 16'(GROUP_NUM);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_CAPTURE,
    S_DONE,
    S_WAIT_TX,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [15:0]   r_pulse_len;
  logic [15:0]   r_group_cnt;
  logic [AW:0]   r_wcnt;
  logic [1:0]    r_guard;
  logic [31:0]   r_mem [0:MAX_LEN-1];

  logic [15:0]   w_len_clamp;
  logic          w_wr_en;
  logic          w_last_wr;
  logic [AW-1:0] w_rd_addr;
  logic          w_unused_addr;

  // Full 16-bit compare so lengths above 2^AW still clamp correctly.
  assign w_len_clamp = (CFG_LEN > MAX_LEN16) ? MAX_LEN16 : CFG_LEN;
  assign w_last_wr   = (16'(r_wcnt) == (r_pulse_len - 16'd1));

  // State register
  always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    RE_OVER     = 1'b0;
    EXECUT_OVER = 1'b0;
    BUSY        = 1'b1;
    case (r_state)
      S_IDLE: begin
        BUSY = 1'b0;
        if (START) w_state_nxt = S_ARM;
      end
      S_ARM: begin
        // A zero-length group skips capture entirely.
        if (TRIG) w_state_nxt = (r_pulse_len == 16'd0) ? S_DONE : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (ADC_VALID) begin
          w_wr_en = 1'b1;
          if (w_last_wr) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        RE_OVER     = 1'b1;
        w_state_nxt = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        // The guard delay keeps a stale OVER=1 from releasing the buffer
        // before the uploader has had time to drop it.
        if ((r_guard == 2'd0) && OVER) w_state_nxt = S_NEXT;
      end
      S_NEXT: begin
        w_state_nxt = (r_group_cnt == GROUP_NUM16) ? S_FINISH : S_ARM;
      end
      S_FINISH: begin
        EXECUT_OVER = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Control counters
  always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pulse_len <= 16'd0;
      r_group_cnt <= 16'd0;
      r_wcnt      <= '0;
      r_guard     <= 2'd0;
    end else begin
      if ((r_state == S_IDLE) && START) begin
        r_pulse_len <= w_len_clamp;
        r_group_cnt <= 16'd0;
      end
      if ((r_state == S_ARM) && TRIG) begin
        r_wcnt <= '0;
      end
      if (w_wr_en) begin
        r_wcnt <= r_wcnt + 1'b1;
      end
      if (r_state == S_DONE) begin
        r_group_cnt <= r_group_cnt + 16'd1;
        r_guard     <= 2'd2;
      end
      if ((r_state == S_WAIT_TX) && (r_guard != 2'd0)) begin
        r_guard <= r_guard - 2'd1;
      end
    end
  end

  // Sample buffer: written only during capture, never reset.
  always_ff @(posedge CLOCK_10M) begin
    if (w_wr_en) begin
      r_mem[r_wcnt[AW-1:0]] <= {ADC_IM, ADC_RE};
    end
  end

  // Asynchronous read: the uploader samples DATA one edge after moving ADDR.
  assign w_rd_addr     = ADDR[AW-1:0];
  assign w_unused_addr = ^ADDR[15:AW];
  assign DATA          = r_mem[w_rd_addr];

  assign PULSE_LEN = r_pulse_len;
  assign GROUP_CNT = r_group_cnt;

endmodule

// File: tb/tb_echo_capture.sv
// Directed testbench for echo_capture (GROUP_NUM=2, MAX_LEN=320).
module tb_echo_capture;

  logic        CLOCK_10M;
  logic        RESET_N;
  logic        START;
  logic        OVER;
  logic [15:0] CFG_LEN;
  logic        TRIG;
  logic        ADC_VALID;
  logic [15:0] ADC_RE;
  logic [15:0] ADC_IM;
  logic [15:0] ADDR;
  logic [31:0] DATA;
  logic [15:0] PULSE_LEN;
  logic        RE_OVER;
  logic        EXECUT_OVER;
  logic        BUSY;
  logic [15:0] GROUP_CNT;

  int n_chk  = 0;
  int n_fail = 0;
  int re_cnt = 0;
  int ex_cnt = 0;

  echo_capture #(
    .GROUP_NUM(2),
    .MAX_LEN  (320),
    .AW       (9)
  ) dut (
    .CLOCK_10M  (CLOCK_10M),
    .RESET_N    (RESET_N),
    .START      (START),
    .OVER       (OVER),
    .CFG_LEN    (CFG_LEN),
    .TRIG       (TRIG),
    .ADC_VALID  (ADC_VALID),
    .ADC_RE     (ADC_RE),
    .ADC_IM     (ADC_IM),
    .ADDR       (ADDR),
    .DATA       (DATA),
    .PULSE_LEN  (PULSE_LEN),
    .RE_OVER    (RE_OVER),
    .EXECUT_OVER(EXECUT_OVER),
    .BUSY       (BUSY),
    .GROUP_CNT  (GROUP_CNT)
  );

  initial begin
    CLOCK_10M = 1'b0;
    forever #50 CLOCK_10M = ~CLOCK_10M;
  end

  // Count high cycles of the one-cycle strobes.
  always @(negedge CLOCK_10M) begin
    if (RE_OVER === 1'b1)     re_cnt++;
    if (EXECUT_OVER === 1'b1) ex_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_10M);
    #1;
  endtask

  task automatic read_chk(input string tag, input logic [15:0] a, input logic [31:0] exp);
    ADDR = a;
    #1;
    chk(tag, DATA, exp);
  endtask

  task automatic start_run(input logic [15:0] len);
    CFG_LEN = len;
    START   = 1'b1;
    tick();
    START   = 1'b0;
  endtask

  // TRIG with a coincident sample that must not be stored.
  task automatic trig_pulse();
    TRIG      = 1'b1;
    ADC_VALID = 1'b1;
    ADC_RE    = 16'hDEAD;
    ADC_IM    = 16'hBEEF;
    tick();
    TRIG      = 1'b0;
    ADC_VALID = 1'b0;
  endtask

  // Feed n samples, gap idle cycles before each; at sample inj_at also
  // pulse START and TRIG, both of which must be ignored.
  task automatic capture(input int n, input int gap, input logic [15:0] re0,
                         input logic [15:0] im0, input int inj_at);
    for (int k = 0; k < n; k++) begin
      ADC_VALID = 1'b0;
      repeat (gap) tick();
      ADC_VALID = 1'b1;
      ADC_RE    = re0 + 16'(k);
      ADC_IM    = im0 + 16'(k);
      if (k == inj_at) begin
        TRIG    = 1'b1;
        START   = 1'b1;
        CFG_LEN = 16'd3;
      end
      if (k == n - 1) chk("re_over_before_last", RE_OVER, 1'b0);
      tick();
      TRIG  = 1'b0;
      START = 1'b0;
    end
    ADC_VALID = 1'b0;
    chk("re_over_after_last", RE_OVER, 1'b1);
  endtask

  // Ticks until EXECUT_OVER is seen, bounded; returns 99 on timeout.
  task automatic wait_ex(output int n);
    n = 99;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (EXECUT_OVER === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  int n_ex;
  int re_snap;

  initial begin
    RESET_N   = 1'b0;
    START     = 1'b0;
    OVER      = 1'b1;
    CFG_LEN   = 16'd0;
    TRIG      = 1'b0;
    ADC_VALID = 1'b0;
    ADC_RE    = 16'd0;
    ADC_IM    = 16'd0;
    ADDR      = 16'd0;
    repeat (3) tick();
    chk("rst_re_over", RE_OVER, 1'b0);
    chk("rst_execut_over", EXECUT_OVER, 1'b0);
    chk("rst_pulse_len", PULSE_LEN, 16'd0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_group_cnt", GROUP_CNT, 16'd0);
    RESET_N = 1'b1;
    tick();

    // Basic run, length 4, uploader handshake on OVER
    start_run(16'd4);
    chk("basic_pulse_len", PULSE_LEN, 16'd4);
    chk("basic_busy", BUSY, 1'b1);
    trig_pulse();
    capture(4, 0, 16'd0, 16'd100, -1);
    chk("basic_gcnt_in_done", GROUP_CNT, 16'd0);
    OVER = 1'b0;
    tick();
    chk("basic_re_over_one_cycle", RE_OVER, 1'b0);
    chk("basic_gcnt_1", GROUP_CNT, 16'd1);
    read_chk("basic_d0", 16'd0, 32'h0064_0000);
    read_chk("basic_d1", 16'd1, 32'h0065_0001);
    read_chk("basic_d2", 16'd2, 32'h0066_0002);
    read_chk("basic_d3", 16'd3, 32'h0067_0003);
    // Held in WAIT_TX while OVER=0; START and TRIG ignored there.
    for (int i = 0; i < 10; i++) begin
      START     = (i == 3);
      CFG_LEN   = 16'd7;
      TRIG      = (i == 5);
      ADC_VALID = (i == 5);
      ADC_RE    = 16'h7777;
      ADC_IM    = 16'h7777;
      tick();
    end
    START = 1'b0; TRIG = 1'b0; ADC_VALID = 1'b0;
    chk("wait_busy", BUSY, 1'b1);
    chk("wait_pulse_len", PULSE_LEN, 16'd4);
    chk("wait_no_exec", ex_cnt, 0);
    read_chk("wait_d0_kept", 16'd0, 32'h0064_0000);
    OVER = 1'b1;
    repeat (6) tick();
    trig_pulse();
    capture(4, 0, 16'h0010, 16'h0200, -1);
    OVER = 1'b0;
    repeat (4) tick();
    chk("basic_no_exec_while_over0", ex_cnt, 0);
    OVER = 1'b1;
    wait_ex(n_ex);
    chk("basic_exec_after_over", n_ex, 2);
    tick();
    chk("basic_exec_one_cycle", EXECUT_OVER, 1'b0);
    chk("basic_re_cnt", re_cnt, 2);
    chk("basic_ex_cnt", ex_cnt, 1);
    chk("basic_gcnt_end", GROUP_CNT, 16'd2);
    chk("basic_len_hold", PULSE_LEN, 16'd4);
    chk("basic_idle", BUSY, 1'b0);
    read_chk("basic_g2_d0", 16'd0, 32'h0200_0010);

    // Clamp: CFG_LEN 1000 -> 320, ignored START/TRIG mid-capture
    start_run(16'd1000);
    chk("clamp_pulse_len", PULSE_LEN, 16'd320);
    trig_pulse();
    capture(320, 0, 16'd0, 16'h3000, -1);
    read_chk("clamp_g1_d0", 16'd0, 32'h3000_0000);
    read_chk("clamp_g1_d319", 16'd319, 32'h313F_013F);
    repeat (6) tick();
    trig_pulse();
    capture(320, 0, 16'd0, 16'h4000, 100);
    chk("clamp_len_not_relatched", PULSE_LEN, 16'd320);
    read_chk("clamp_g2_d0", 16'd0, 32'h4000_0000);
    read_chk("clamp_g2_d100", 16'd100, 32'h4064_0064);
    read_chk("clamp_g2_d319", 16'd319, 32'h413F_013F);
    wait_ex(n_ex);
    chk("guard_exec_latency", n_ex, 5);

    // Strobe gaps: ADC_VALID every 3rd cycle, length 5
    tick();
    start_run(16'd5);
    trig_pulse();
    capture(5, 2, 16'h0010, 16'h0020, -1);
    for (int a = 0; a < 5; a++) begin
      read_chk("gap_word", 16'(a), {16'h0020 + 16'(a), 16'h0010 + 16'(a)});
    end
    read_chk("gap_d5_untouched", 16'd5, 32'h4005_0005);
    repeat (6) tick();
    trig_pulse();
    capture(5, 2, 16'h0050, 16'h0060, -1);
    wait_ex(n_ex);
    chk("gap_exec_latency", n_ex, 5);
    read_chk("gap_g2_d0", 16'd0, 32'h0060_0050);

    // TRIG while idle writes nothing; then zero-length run
    tick();
    TRIG = 1'b1; ADC_VALID = 1'b1; ADC_RE = 16'hEEEE; ADC_IM = 16'hEEEE;
    repeat (2) tick();
    TRIG = 1'b0; ADC_VALID = 1'b0;
    chk("idle_trig_busy", BUSY, 1'b0);
    read_chk("idle_trig_d0", 16'd0, 32'h0060_0050);
    start_run(16'd0);
    chk("zero_pulse_len", PULSE_LEN, 16'd0);
    trig_pulse();
    chk("zero_re_over_next", RE_OVER, 1'b1);
    ADC_VALID = 1'b1; ADC_RE = 16'h1111; ADC_IM = 16'h2222;
    repeat (6) tick();
    TRIG = 1'b1;
    tick();
    TRIG = 1'b0;
    chk("zero_g2_re_over", RE_OVER, 1'b1);
    wait_ex(n_ex);
    chk("zero_exec_latency", n_ex, 5);
    ADC_VALID = 1'b0;
    read_chk("zero_d0_kept", 16'd0, 32'h0060_0050);
    read_chk("zero_d1_kept", 16'd1, 32'h0061_0051);

    // Reset in the middle of a capture
    tick();
    start_run(16'd4);
    trig_pulse();
    for (int k = 0; k < 2; k++) begin
      ADC_VALID = 1'b1;
      ADC_RE    = 16'h0070 + 16'(k);
      ADC_IM    = 16'h0070 + 16'(k);
      tick();
    end
    ADC_VALID = 1'b0;
    re_snap = re_cnt;
    #20 RESET_N = 1'b0;
    #1;
    chk("mid_rst_busy", BUSY, 1'b0);
    chk("mid_rst_pulse_len", PULSE_LEN, 16'd0);
    chk("mid_rst_gcnt", GROUP_CNT, 16'd0);
    chk("mid_rst_re_over", RE_OVER, 1'b0);
    chk("mid_rst_exec", EXECUT_OVER, 1'b0);
    repeat (3) tick();
    RESET_N = 1'b1;
    repeat (2) tick();
    chk("mid_rst_no_re_over", re_cnt, re_snap);
    start_run(16'd4);
    chk("post_rst_pulse_len", PULSE_LEN, 16'd4);
    trig_pulse();
    capture(4, 0, 16'h0080, 16'h0090, -1);
    read_chk("post_rst_d0", 16'd0, 32'h0090_0080);
    read_chk("post_rst_d3", 16'd3, 32'h0093_0083);
    repeat (6) tick();
    trig_pulse();
    capture(4, 0, 16'h00A0, 16'h00B0, -1);
    wait_ex(n_ex);
    chk("post_rst_exec_latency", n_ex, 5);
    chk("post_rst_gcnt", GROUP_CNT, 16'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/echo_capture.md
# echo_capture

Capture stage directly upstream of the UART uploader. On START it runs GROUP_NUM probe groups. Each group arms on a trigger, writes PULSE_LEN complex ADC samples into an internal buffer, pulses RE_OVER, then holds the buffer stable while the uploader reads it out by ADDR. After the last group it pulses EXECUT_OVER.

## Interface
- GROUP_NUM, 8: probe groups per run (1..65535).
- MAX_LEN, 320: buffer depth in 32-bit words.
- AW, 9: buffer address width; 2^AW >= MAX_LEN.
- CLOCK_10M  in  1  sole clock.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle run request from uploader.
- OVER  in  1  uploader idle/done level: 0 while uploading, 1 when done.
- CFG_LEN  in  16  requested samples per group.
- TRIG  in  1  pulse-start strobe.
- ADC_VALID  in  1  sample strobe.
- ADC_RE  in  16  real sample.
- ADC_IM  in  16  imaginary sample.
- ADDR  in  16  uploader read address.
- DATA  out  32  {IM, RE} at ADDR.
- PULSE_LEN  out  16  clamped length latched at START.
- RE_OVER  out  1  one-cycle pulse: group buffer ready.
- EXECUT_OVER  out  1  one-cycle pulse: run complete.
- BUSY  out  1  high in every state except IDLE.
- GROUP_CNT  out  16  groups completed in current run.

## Operation
- Reset values: RE_OVER=0, EXECUT_OVER=0, PULSE_LEN=0, BUSY=0, GROUP_CNT=0, state IDLE. Buffer contents are not reset.
- IDLE: on START=1, latch PULSE_LEN = min(CFG_LEN, MAX_LEN), clear GROUP_CNT, go to ARM. START is ignored in every other state.
- ARM: on TRIG=1, clear write counter wcnt and go to CAPTURE. If PULSE_LEN==0, go straight to DONE instead.
- CAPTURE: each cycle with ADC_VALID=1 writes mem[wcnt] <= {ADC_IM, ADC_RE} and increments wcnt. When the write at wcnt==PULSE_LEN-1 occurs, go to DONE. Gaps in ADC_VALID stretch the capture. TRIG is ignored.
- DONE: assert RE_OVER for exactly one cycle, increment GROUP_CNT, load guard counter = 2, go to WAIT_TX.
- WAIT_TX: decrement guard to 0. Once guard==0 and OVER==1, go to NEXT. The guard prevents a stale OVER=1 from being taken before the uploader has dropped it.
- NEXT: if GROUP_CNT==GROUP_NUM, go to FINISH; otherwise go to ARM.
- FINISH: assert EXECUT_OVER for exactly one cycle, go to IDLE. PULSE_LEN and GROUP_CNT hold their values until the next START.
- Read port: DATA = mem[ADDR[AW-1:0]] is asynchronous (combinational). It must be valid in the same cycle ADDR changes, because the uploader samples DATA one edge after updating ADDR.
- ADDR >= MAX_LEN returns an undefined value. The uploader never issues such an address.
- The buffer is written only in CAPTURE, so it is stable throughout WAIT_TX.
- RESET_N low mid-operation: immediately return to IDLE with all outputs at reset values. An in-progress group is abandoned and no RE_OVER is issued.

## Timing
- A TRIG sampled at edge t in ARM moves to CAPTURE at t. The first capturable ADC_VALID is at edge t+1. A sample whose ADC_VALID coincides with TRIG is not stored.
- RE_OVER is high for the cycle after the edge that wrote the last sample.
- PULSE_LEN==0: RE_OVER is high the cycle after the TRIG edge.
- The earliest exit from WAIT_TX is 3 edges after RE_OVER rises.
- EXECUT_OVER rises 2 edges after the WAIT_TX exit (via NEXT, then FINISH). It is never level-held, so a following START can never be paired with a stale EXECUT_OVER.
- Write and read use separate ports, so a write and a read at the same address in one cycle return the old word. This cannot occur in normal flow.
- Width rules:
  - wcnt is AW+1 bits.
  - GROUP_CNT is 16 bits and never wraps, since the run ends at GROUP_NUM.
  - The clamp compares the full 16-bit CFG_LEN against MAX_LEN.

## Test plan
- Basic run: GROUP_NUM=2, CFG_LEN=4, ADC_VALID continuous, RE=k, IM=100+k. Required response:
  - RE_OVER fires once per group.
  - DATA at ADDR 0..3 is 0x00640000, 0x00650001, 0x00660002, 0x00670003.
  - EXECUT_OVER is pulsed once, after OVER returns high following the second RE_OVER.
- Strobe gaps: ADC_VALID every 3rd cycle, CFG_LEN=5 -> exactly 5 words stored, and RE_OVER one cycle after the 5th write.
- Clamp and zero length:
  - CFG_LEN=1000 -> PULSE_LEN=320, and 320 words are captured.
  - CFG_LEN=0 -> RE_OVER the cycle after TRIG, and no writes occur.
- Handshake guard: OVER held at 1 throughout (uploader stalled model) -> WAIT_TX still lasts at least 3 cycles. With OVER=0 held, the block stays in WAIT_TX indefinitely, and TRIG and START are ignored.
- Ignored inputs:
  - START during CAPTURE does not relatch PULSE_LEN.
  - A second TRIG during CAPTURE does not restart wcnt.
  - TRIG in IDLE produces no writes.
- Reset mid-capture: assert RESET_N low after 2 of 4 samples. Required response:
  - All outputs return to 0 asynchronously and no RE_OVER is issued.
  - A new START with CFG_LEN=4 completes a normal group.
